// File: rtl/dbg_view_pkg.sv
// dbg_view_pkg: shared types for the register snapshot / VGA debug view path
package dbg_view_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0] regidx_t;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_COMMIT} state_t;
    localparam int DBG_NREGS = 32;
endpackage

// File: rtl/reg_change_timer.sv
// reg_change_timer: per-register highlight hold counter, reloaded on change, decays per frame
module reg_change_timer #(
    parameter int HOLD_FRAMES = 60
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic load_i,
    input  logic tick_i,
    output logic active_o
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    logic [HW-1:0] hold_q;
    always_ff @(posedge clk_i) begin
        if (!reset_ni) hold_q <= '0;
        else if (load_i) hold_q <= HW'(HOLD_FRAMES);
        else if (tick_i && hold_q != '0) hold_q <= hold_q - 1'b1;
    end
    assign active_o = hold_q != '0;
endmodule

// File: rtl/reg_snapshot_scheduler.sv
// reg_snapshot_scheduler: per-frame scan of x1..x31 via the debug port, atomic commit to a shadow bank
module reg_snapshot_scheduler
    import dbg_view_pkg::*;
#(
    parameter int NREGS       = DBG_NREGS,
    parameter int HOLD_FRAMES = 60,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             frame_start_i,
    input  logic             freeze_i,
    output logic             dbg_req_o,
    output regidx_t          dbg_addr_o,
    input  logic             dbg_ack_i,
    input  word_t            dbg_rdata_i,
    output word_t            regs_shadow_o [NREGS],
    output logic [NREGS-1:0] changed_mask_o,
    output logic             busy_o,
    output logic             snap_done_o,
    output logic             err_timeout_o
);
    localparam int WW = $clog2(TIMEOUT + 1);
    state_t        state_q;
    regidx_t       addr_q;
    logic [WW-1:0] wait_q, wait_d;
    word_t         stage_q [NREGS];
    word_t         shadow_q [NREGS];
    logic          primed_q, snap_done_q, err_q;
    logic          tmo, step;
    always_comb begin
        wait_d = wait_q + 1'b1;
        tmo    = state_q == S_READ && !dbg_ack_i && wait_d == WW'(TIMEOUT);
        step   = state_q == S_READ && (dbg_ack_i || tmo);
    end
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wait_q      <= '0;
            primed_q    <= 1'b0;
            snap_done_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                stage_q[i]  <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            snap_done_q <= state_q == S_COMMIT;
            case (state_q)
                S_IDLE: if (frame_start_i && !freeze_i) begin
                    state_q    <= S_READ;
                    addr_q     <= regidx_t'(1);
                    wait_q     <= '0;
                    stage_q[0] <= '0;
                end
                S_READ: if (step) begin
                    // a timed-out read keeps the currently displayed value
                    stage_q[addr_q] <= dbg_ack_i ? dbg_rdata_i : shadow_q[addr_q];
                    wait_q          <= '0;
                    err_q           <= err_q | tmo;
                    if (addr_q == regidx_t'(NREGS - 1)) state_q <= S_COMMIT;
                    else addr_q <= addr_q + 1'b1;
                end else wait_q <= wait_d;
                S_COMMIT: begin
                    shadow_q <= stage_q;
                    primed_q <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    for (genvar i = 0; i < NREGS; i++) begin : g_t
        if (i == 0) begin : g_x0
            assign changed_mask_o[0] = 1'b0;
        end else begin : g_xn
            reg_change_timer #(.HOLD_FRAMES(HOLD_FRAMES)) u_timer (
                .clk_i,
                .reset_ni,
                .load_i  (state_q == S_COMMIT && primed_q && stage_q[i] != shadow_q[i]),
                .tick_i  (frame_start_i),
                .active_o(changed_mask_o[i])
            );
        end
    end
    assign dbg_req_o     = state_q == S_READ;
    assign dbg_addr_o    = addr_q;
    assign busy_o        = state_q != S_IDLE;
    assign snap_done_o   = snap_done_q;
    assign err_timeout_o = err_q;
    assign regs_shadow_o = shadow_q;
endmodule

// File: tb/tb_reg_snapshot_scheduler.sv
// tb_reg_snapshot_scheduler: directed bench with a debug-port responder and a shadow-bank model
module tb_reg_snapshot_scheduler;
    logic        clk = 1'b0;
    logic        reset_n, frame_start, freeze, dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_req, busy, snap_done, err;
    logic [4:0]  dbg_addr;
    logic [31:0] shadow [32];
    logic [31:0] mask;

    reg_snapshot_scheduler #(.NREGS(32), .HOLD_FRAMES(3), .TIMEOUT(4)) dut (
        .clk_i(clk), .reset_ni(reset_n), .frame_start_i(frame_start), .freeze_i(freeze),
        .dbg_req_o(dbg_req), .dbg_addr_o(dbg_addr), .dbg_ack_i(dbg_ack), .dbg_rdata_i(dbg_rdata),
        .regs_shadow_o(shadow), .changed_mask_o(mask), .busy_o(busy),
        .snap_done_o(snap_done), .err_timeout_o(err)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    int          mode = 0, stall_cnt = 0, dly = 0;
    logic [31:0] base = 32'h1000;
    bit          alt = 0, pending = 0, req_prev = 0;
    logic [4:0]  prev_addr = '0, after9 = '0;
    logic [31:0] stage_m [32], sh_m [32], old_m [32];

    typedef struct {
        bit        fs;
        bit        frz;
        bit        busy;
        bit        req;
        bit [4:0]  addr;
        bit [31:0] mask;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one clock: sample just after the edge, then drive the debug-port response for the next edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (snap_done) sh_m = stage_m;
        if (mode == 2 && pending) chk("addr_stable", {26'd0, dbg_req, dbg_addr}, {26'd0, 1'b1, prev_addr});
        if (mode == 1 && dbg_req && prev_addr == 5'd9 && dbg_addr != 5'd9) after9 = dbg_addr;
        if (dbg_req && !req_prev) begin
            stage_m = sh_m;
            stage_m[0] = '0;
        end
        dbg_ack = 1'b0;
        dbg_rdata = '0;
        if (dbg_req) begin
            if (mode == 1 && dbg_addr == 5'd9) stall_cnt++;
            if (mode == 0) dbg_ack = 1'b1;
            else if (mode == 1) dbg_ack = dbg_addr != 5'd9;
            else begin
                if (!pending) dly = $urandom_range(3);
                dbg_ack = dly == 0;
                if (dly != 0) dly--;
            end
            dbg_rdata = mode == 2 ? $urandom : (alt && dbg_addr == 5'd7) ? 32'hDEADBEEF : base + {27'd0, dbg_addr};
            if (dbg_ack) stage_m[dbg_addr] = dbg_rdata;
        end
        pending = dbg_req && !dbg_ack;
        prev_addr = dbg_addr;
        req_prev = dbg_req;
    endtask

    task automatic start_scan();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_snap(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!snap_done && n < 300);
        chk("snap_seen", {31'd0, snap_done}, 32'd1);
    endtask

    task automatic chk_shadow(string tag);
        for (int i = 0; i < 32; i++) chk($sformatf("%s_shadow[%0d]", tag, i), shadow[i], sh_m[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, g;
        logic [31:0] em;
        tbl[0] = '{fs: 1, frz: 1, busy: 0, req: 0, addr: 0, mask: 32'h80};
        tbl[1] = '{fs: 0, frz: 1, busy: 0, req: 0, addr: 0, mask: 32'h80};
        tbl[2] = '{fs: 1, frz: 0, busy: 1, req: 1, addr: 1, mask: 32'h80};
        tbl[3] = '{fs: 0, frz: 0, busy: 1, req: 1, addr: 2, mask: 32'h80};
        tbl[4] = '{fs: 1, frz: 0, busy: 1, req: 1, addr: 3, mask: 32'h0};
        for (int i = 0; i < 32; i++) begin
            sh_m[i] = '0;
            stage_m[i] = '0;
        end
        reset_n = 1'b0; frame_start = 1'b0; freeze = 1'b0; dbg_ack = 1'b0; dbg_rdata = '0;
        repeat (2) tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_req", {31'd0, dbg_req}, 0);
        chk("rst_snap", {31'd0, snap_done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_mask", mask, 0);
        chk("rst_shadow5", shadow[5], 0);
        reset_n = 1'b1;
        tick();

        // 1: first scan, zero-wait acks
        start_scan();
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_req", {31'd0, dbg_req}, 1);
        chk("t1_addr", {27'd0, dbg_addr}, 1);
        for (int k = 2; k <= 31; k++) begin
            tick();
            chk($sformatf("t1_addr%0d", k), {27'd0, dbg_addr}, k);
        end
        tick();
        chk("t1_snap_early", {31'd0, snap_done}, 0);
        chk("t1_busy_commit", {31'd0, busy}, 1);
        tick();
        chk("t1_snap", {31'd0, snap_done}, 1);
        chk("t1_busy_done", {31'd0, busy}, 0);
        chk("t1_shadow5", shadow[5], 32'h00001005);
        chk("t1_shadow0", shadow[0], 0);
        chk("t1_mask", mask, 0);
        chk_shadow("t1");
        tick();
        chk("t1_snap_pulse", {31'd0, snap_done}, 0);

        // 2: register 7 changes
        alt = 1;
        start_scan();
        wait_snap(n);
        chk("t2_latency", n, 32);
        chk("t2_mask", mask, 32'h80);
        chk("t2_shadow7", shadow[7], 32'hDEADBEEF);
        chk_shadow("t2");

        // hold decay, freeze, mid-scan frame_start
        for (int r = 0; r < 5; r++) begin
            frame_start = tbl[r].fs;
            freeze = tbl[r].frz;
            tick();
            chk($sformatf("tbl%0d_busy", r), {31'd0, busy}, {31'd0, tbl[r].busy});
            chk($sformatf("tbl%0d_req", r), {31'd0, dbg_req}, {31'd0, tbl[r].req});
            chk($sformatf("tbl%0d_mask", r), mask, tbl[r].mask);
            if (tbl[r].busy) chk($sformatf("tbl%0d_addr", r), {27'd0, dbg_addr}, {27'd0, tbl[r].addr});
        end
        frame_start = 1'b0;
        freeze = 1'b0;
        wait_snap(n);
        chk("t4_latency", n, 30);
        tick();
        chk("t4_no_restart", {31'd0, busy}, 0);
        chk("t4_mask", mask, 0);
        chk_shadow("t4");

        // 3: timeout on register 9
        mode = 1; base = 32'h2000; alt = 0; stall_cnt = 0;
        chk("t3_err_pre", {31'd0, err}, 0);
        start_scan();
        wait_snap(n);
        chk("t3_stall_cycles", stall_cnt, 4);
        chk("t3_after9", {27'd0, after9}, 10);
        chk("t3_err", {31'd0, err}, 1);
        chk("t3_shadow9", shadow[9], 32'h00001009);
        chk("t3_shadow10", shadow[10], 32'h0000200A);
        chk("t3_mask", mask, 32'hFFFFFDFE);
        chk_shadow("t3");

        // 5: reset mid-scan at addr 15
        mode = 0; base = 32'h3000;
        start_scan();
        g = 0;
        while (dbg_addr != 5'd15 && g < 40) begin
            tick();
            g++;
        end
        chk("t5_at15", {27'd0, dbg_addr}, 15);
        chk("t5_err_sticky", {31'd0, err}, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) sh_m[i] = '0;
        chk("t5_req", {31'd0, dbg_req}, 0);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_err", {31'd0, err}, 0);
        chk("t5_mask", mask, 0);
        chk_shadow("t5rst");
        tick();
        start_scan();
        chk("t5_restart_addr", {27'd0, dbg_addr}, 1);
        wait_snap(n);
        chk("t5_latency", n, 32);
        chk("t5_mask_unprimed", mask, 0);
        chk_shadow("t5");

        // 6: random ack delays
        mode = 2; pending = 0;
        for (int s = 0; s < 2; s++) begin
            old_m = sh_m;
            start_scan();
            wait_snap(n);
            chk_shadow($sformatf("t6s%0d", s));
            if (s == 0) begin
                em = '0;
                for (int i = 1; i < 32; i++) em[i] = sh_m[i] != old_m[i];
                chk("t6_mask", mask, em);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
